// File: rtl/abs_dif_pkg.sv
// Shared types and constants for the abs_dif scheduler slice.
package abs_dif_pkg;

    localparam int W = 4;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_SUB  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CMP  = ST_CMP,
        SUB  = ST_SUB,
        RESP = ST_RESP
    } state_t;

    typedef struct packed {
        logic agb;
        logic aeb;
        logic alb;
    } flags_t;

endpackage

// File: rtl/abs_dif_sched_if.sv
// Request/grant and response bus between two requesters and the abs_dif scheduler.
interface abs_dif_sched_if #(parameter int W = abs_dif_pkg::W);

    logic         req0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         req1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         vld;
    logic         id;
    logic [W-1:0] dif;
    logic         agb;
    logic         aeb;
    logic         alb;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, busy, vld, id, dif, agb, aeb, alb
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, busy, vld, id, dif, agb, aeb, alb
    );

endinterface

// File: rtl/abs_dif_rr_arb.sv
// Two-way round-robin pick between req0/req1; the channel not served last wins a tie.
// Latency: combinational.
// Backpressure: none; en gates the pick so nothing is selected while the datapath is busy.
module abs_dif_rr_arb
    import abs_dif_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_id,
    input  logic       en,
    output logic [1:0] win_oh,
    output logic       win_id
);

    always_comb begin
        win_oh = 2'b00;
        win_id = CH0;
        if (en) begin
            if (req0 && req1) begin
                if (last_id == CH1) begin
                    win_oh = 2'b01;
                    win_id = CH0;
                end else begin
                    win_oh = 2'b10;
                    win_id = CH1;
                end
            end else if (req0) begin
                win_oh = 2'b01;
                win_id = CH0;
            end else if (req1) begin
                win_oh = 2'b10;
                win_id = CH1;
            end
        end
    end

endmodule

// File: rtl/abs_dif_sched.sv
// Time-shares one compare/subtract datapath between two requesters, returning |a-b| and flags.
// Latency: gnt at G, vld at G+2; next gnt no earlier than G+4.
// Backpressure: requests are level-held and simply wait while busy; no response stall.
module abs_dif_sched
    import abs_dif_pkg::*;
#(
    parameter int W = abs_dif_pkg::W
)(
    input  logic            clk,
    input  logic            rst_n,
    abs_dif_sched_if.slave  bus
);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         id_r;
    flags_t       flg_r;
    logic         rr_ptr;

    logic         gnt0_r;
    logic         gnt1_r;
    logic         busy_r;
    logic         vld_r;
    logic         id_q;
    logic [W-1:0] dif_r;
    flags_t       flg_q;

    logic [1:0]   win_oh;
    logic         win_id;
    logic         arb_en;

    assign arb_en = (state == IDLE);

    abs_dif_rr_arb u_arb (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .last_id (rr_ptr),
        .en      (arb_en),
        .win_oh  (win_oh),
        .win_id  (win_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_oh != 2'b00) state_nxt = CMP;
            CMP:     state_nxt = SUB;
            SUB:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result outputs (dif/flags/id) load at the SUB edge so they appear in RESP and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            id_r   <= CH0;
            flg_r  <= '0;
            rr_ptr <= CH1;
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            busy_r <= 1'b0;
            vld_r  <= 1'b0;
            id_q   <= CH0;
            dif_r  <= '0;
            flg_q  <= '0;
        end else begin
            gnt0_r <= win_oh[0];
            gnt1_r <= win_oh[1];
            busy_r <= (state_nxt != IDLE);
            vld_r  <= (state == SUB);
            case (state)
                IDLE: begin
                    if (win_oh != 2'b00) begin
                        op_a <= (win_id == CH1) ? bus.a1 : bus.a0;
                        op_b <= (win_id == CH1) ? bus.b1 : bus.b0;
                        id_r <= win_id;
                    end
                end
                CMP: begin
                    flg_r <= {op_a > op_b, op_a == op_b, op_a < op_b};
                end
                SUB: begin
                    dif_r <= flg_r.agb ? (op_a - op_b) : (op_b - op_a);
                    flg_q <= flg_r;
                    id_q  <= id_r;
                end
                RESP: begin
                    rr_ptr <= id_r;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0 = gnt0_r;
    assign bus.gnt1 = gnt1_r;
    assign bus.busy = busy_r;
    assign bus.vld  = vld_r;
    assign bus.id   = id_q;
    assign bus.dif  = dif_r;
    assign bus.agb  = flg_q.agb;
    assign bus.aeb  = flg_q.aeb;
    assign bus.alb  = flg_q.alb;

endmodule

// File: tb/tb_abs_dif_sched.sv
// Directed bench for abs_dif_sched: fixed-cycle expectations on the whole response bus.
module tb_abs_dif_sched;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    abs_dif_sched_if #(.W(4)) bus ();

    abs_dif_sched #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {gnt0, gnt1, busy, vld, id, dif[3:0], agb, aeb, alb}
    logic [11:0] obs;
    assign obs = {bus.gnt0, bus.gnt1, bus.busy, bus.vld, bus.id, bus.dif, bus.agb, bus.aeb, bus.alb};

    function automatic logic [11:0] ex(int g0, int g1, int bs, int v, int i, int d, int gt, int eq, int lt);
        return {g0[0], g1[0], bs[0], v[0], i[0], d[3:0], gt[0], eq[0], lt[0]};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = 4'd0; bus.b0 = 4'd0; bus.a1 = 4'd0; bus.b1 = 4'd0;
        step();
        step();
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_asserted: obs=%03h exp=%03h", obs, 12'h000);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_idle: obs=%03h exp=%03h", obs, 12'h000);
        end
    endtask

    task automatic test_lt_ch0();
        logic [11:0] e [4];
        e[0] = ex(1,0,1,0,0, 0,0,0,0);
        e[1] = ex(0,0,1,0,0, 0,0,0,0);
        e[2] = ex(0,0,1,1,0,10,0,0,1);
        e[3] = ex(0,0,0,0,0,10,0,0,1);
        bus.a0 = 4'd3; bus.b0 = 4'd13; bus.req0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (obs !== e[k]) begin
                errors++;
                $display("FAIL lt_ch0 cyc%0d: obs=%03h exp=%03h", k, obs, e[k]);
            end
            bus.req0 = 1'b0;
        end
    endtask

    task automatic test_gt_ch1();
        logic [11:0] e [4];
        e[0] = ex(0,1,1,0,0,10,0,0,1);
        e[1] = ex(0,0,1,0,0,10,0,0,1);
        e[2] = ex(0,0,1,1,1,14,1,0,0);
        e[3] = ex(0,0,0,0,1,14,1,0,0);
        bus.a1 = 4'd15; bus.b1 = 4'd1; bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (obs !== e[k]) begin
                errors++;
                $display("FAIL gt_ch1 cyc%0d: obs=%03h exp=%03h", k, obs, e[k]);
            end
            bus.req1 = 1'b0;
        end
    endtask

    task automatic test_equal();
        logic [11:0] e [4];
        e[0] = ex(1,0,1,0,1,14,1,0,0);
        e[1] = ex(0,0,1,0,1,14,1,0,0);
        e[2] = ex(0,0,1,1,0, 0,0,1,0);
        e[3] = ex(0,0,0,0,0, 0,0,1,0);
        bus.a0 = 4'd5; bus.b0 = 4'd5; bus.req0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (obs !== e[k]) begin
                errors++;
                $display("FAIL equal cyc%0d: obs=%03h exp=%03h", k, obs, e[k]);
            end
            bus.req0 = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e [12];
        int last_v;
        e[0]  = ex(1,0,1,0,0,0,0,0,0);
        e[1]  = ex(0,0,1,0,0,0,0,0,0);
        e[2]  = ex(0,0,1,1,0,1,1,0,0);
        e[3]  = ex(0,0,0,0,0,1,1,0,0);
        e[4]  = ex(0,1,1,0,0,1,1,0,0);
        e[5]  = ex(0,0,1,0,0,1,1,0,0);
        e[6]  = ex(0,0,1,1,1,6,0,0,1);
        e[7]  = ex(0,0,0,0,1,6,0,0,1);
        e[8]  = ex(1,0,1,0,1,6,0,0,1);
        e[9]  = ex(0,0,1,0,1,6,0,0,1);
        e[10] = ex(0,0,1,1,0,1,1,0,0);
        e[11] = ex(0,0,0,0,0,1,1,0,0);
        last_v = -1;
        apply_reset();
        bus.a0 = 4'd10; bus.b0 = 4'd9; bus.req0 = 1'b1;
        bus.a1 = 4'd0;  bus.b1 = 4'd6; bus.req1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (obs !== e[k]) begin
                errors++;
                $display("FAIL back_to_back cyc%0d: obs=%03h exp=%03h", k, obs, e[k]);
            end
            if (bus.vld === 1'b1) begin
                if (last_v >= 0) begin
                    checks++;
                    if (k - last_v != 4) begin
                        errors++;
                        $display("FAIL vld_spacing: got %0d cycles exp 4", k - last_v);
                    end
                end
                last_v = k;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    task automatic test_wait_busy();
        logic [11:0] e [8];
        e[0] = ex(1,0,1,0,0,1,1,0,0);
        e[1] = ex(0,0,1,0,0,1,1,0,0);
        e[2] = ex(0,0,1,1,0,2,0,0,1);
        e[3] = ex(0,0,0,0,0,2,0,0,1);
        e[4] = ex(0,1,1,0,0,2,0,0,1);
        e[5] = ex(0,0,1,0,0,2,0,0,1);
        e[6] = ex(0,0,1,1,1,5,1,0,0);
        e[7] = ex(0,0,0,0,1,5,1,0,0);
        bus.a0 = 4'd11; bus.b0 = 4'd13; bus.req0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (obs !== e[k]) begin
                errors++;
                $display("FAIL wait_busy cyc%0d: obs=%03h exp=%03h", k, obs, e[k]);
            end
            if (k == 0) bus.req0 = 1'b0;
            if (k == 1) begin
                bus.a1 = 4'd7; bus.b1 = 4'd2; bus.req1 = 1'b1;
            end
            if (k == 4) bus.req1 = 1'b0;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [11:0] e [8];
        bus.a0 = 4'd0; bus.b0 = 4'd15; bus.req0 = 1'b1;
        step();
        checks++;
        if (obs !== ex(1,0,1,0,1,5,1,0,0)) begin
            errors++;
            $display("FAIL midrst_gnt: obs=%03h exp=%03h", obs, ex(1,0,1,0,1,5,1,0,0));
        end
        bus.req0 = 1'b0;
        step();
        checks++;
        if (obs !== ex(0,0,1,0,1,5,1,0,0)) begin
            errors++;
            $display("FAIL midrst_sub: obs=%03h exp=%03h", obs, ex(0,0,1,0,1,5,1,0,0));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL midrst_async_clear: obs=%03h exp=%03h", obs, 12'h000);
        end
        step();
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL midrst_no_vld: obs=%03h exp=%03h", obs, 12'h000);
        end
        rst_n = 1'b1;
        e[0] = ex(1,0,1,0,0, 0,0,0,0);
        e[1] = ex(0,0,1,0,0, 0,0,0,0);
        e[2] = ex(0,0,1,1,0,15,0,0,1);
        e[3] = ex(0,0,0,0,0,15,0,0,1);
        e[4] = ex(0,1,1,0,0,15,0,0,1);
        e[5] = ex(0,0,1,0,0,15,0,0,1);
        e[6] = ex(0,0,1,1,1, 0,0,1,0);
        e[7] = ex(0,0,0,0,1, 0,0,1,0);
        bus.a0 = 4'd0; bus.b0 = 4'd15; bus.req0 = 1'b1;
        bus.a1 = 4'd4; bus.b1 = 4'd4;  bus.req1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (obs !== e[k]) begin
                errors++;
                $display("FAIL after_reset cyc%0d: obs=%03h exp=%03h", k, obs, e[k]);
            end
            if (k == 0) bus.req0 = 1'b0;
            if (k == 4) bus.req1 = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lt_ch0();
        test_gt_ch1();
        test_equal();
        test_back_to_back();
        test_wait_busy();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
